// File: rtl/ecg_window_buffer_if.sv
// ecg_window_buffer_if: column stream in, window column stream out.
// Both streams use valid/ready: a transfer happens on a rising clk edge where
// valid && ready are both high; the source holds data stable while valid is
// high and ready is low, and valid never waits on ready.
// Optional out_sum signal is present only when ECG_WIN_SUM_EN is defined.
interface ecg_window_buffer_if #(
  parameter int N_CH    = 8,
  parameter int N_BITS  = 22,
  parameter int WIN_LEN = 32
);
  localparam int AW = $clog2(WIN_LEN);

  logic                     in_valid;
  logic                     in_ready;
  logic [N_CH*N_BITS-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_CH*N_BITS-1:0]   out_data;
  logic [AW-1:0]            out_idx;
  logic                     out_last;
`ifdef ECG_WIN_SUM_EN
  logic [N_CH*(N_BITS+AW)-1:0] out_sum;
`endif

  // Producer of columns / consumer of windows (the environment side).
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
`ifdef ECG_WIN_SUM_EN
    , input out_sum
`endif
  );

  // The window buffer itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
`ifdef ECG_WIN_SUM_EN
    , output out_sum
`endif
  );
endinterface

// File: rtl/ecg_window_buffer.sv
// ecg_window_buffer: collects ECG sample columns into a circular buffer and
// replays each (optionally overlapping) window oldest-first.
// Optional feature macro: ECG_WIN_SUM_EN adds per-channel window sums on
// out_sum, valid with out_valid && out_last.
// o_dbg_state exposes the FSM state (0 IDLE, 1 FILL, 2 EMIT).
module ecg_window_buffer #(
  parameter int N_CH    = 8,
  parameter int N_BITS  = 22,
  parameter int WIN_LEN = 32,
  parameter int HOP     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   strt,
  ecg_window_buffer_if.slave     bus,
  output logic                   busy,
  output logic [15:0]            win_cnt,
  output logic [1:0]             o_dbg_state
);
  localparam int AW = $clog2(WIN_LEN);
  localparam int CW = AW + 1;           // fill count must reach WIN_LEN
  localparam int DW = N_CH * N_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_out_idx;
  logic [CW-1:0]   r_fill_cnt;
  logic [CW-1:0]   r_fill_tgt;
  logic [15:0]     r_win_cnt;
  logic [DW-1:0]   r_mem [WIN_LEN];

  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_out_last;
  logic            w_busy;
  logic            w_acc;
  logic            w_emit_hs;
  logic            w_idx_last;
  logic            w_fill_last;
  logic [AW-1:0]   w_rd_ptr;

  // Accept only while running: a column offered as strt drops would be
  // discarded with the rest of the partial fill anyway.
  assign w_acc       = (r_state == S_FILL) && strt && bus.in_valid;
  assign w_emit_hs   = (r_state == S_EMIT) && bus.out_ready;
  assign w_idx_last  = (r_out_idx == AW'(WIN_LEN - 1));
  assign w_fill_last = ((r_fill_cnt + CW'(1)) == r_fill_tgt);
  // After a fill the write pointer sits on the oldest column; power-of-two
  // depth makes the modulo a plain wrap.
  assign w_rd_ptr    = r_wr_ptr + r_out_idx;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_out_last  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (strt) w_next = S_FILL;
      end
      S_FILL: begin
        w_busy     = 1'b1;
        w_in_ready = strt;
        if (!strt)                    w_next = S_IDLE;
        else if (w_acc && w_fill_last) w_next = S_EMIT;
      end
      S_EMIT: begin
        w_busy      = 1'b1;
        w_out_valid = 1'b1;
        w_out_last  = w_idx_last;
        if (w_emit_hs && w_idx_last) w_next = strt ? S_FILL : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Pointers, fill bookkeeping and window counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_out_idx  <= '0;
      r_fill_cnt <= '0;
      r_fill_tgt <= CW'(WIN_LEN);
      r_win_cnt  <= '0;
    end else begin
      // A fresh start (or restart after strt dropped) needs a full window.
      if ((r_state == S_IDLE && strt) || (r_state == S_FILL && !strt)) begin
        r_fill_cnt <= '0;
        r_fill_tgt <= CW'(WIN_LEN);
      end
      if (w_acc) begin
        r_wr_ptr   <= r_wr_ptr + AW'(1);
        r_fill_cnt <= r_fill_cnt + CW'(1);
      end
      if (w_emit_hs) begin
        if (w_idx_last) begin
          r_out_idx  <= '0;
          r_win_cnt  <= r_win_cnt + 16'd1;
          r_fill_cnt <= '0;
          r_fill_tgt <= CW'(HOP);
        end else begin
          r_out_idx  <= r_out_idx + AW'(1);
        end
      end
    end
  end

  // Column storage; contents are only read after a complete fill.
  always_ff @(posedge clk) begin
    if (w_acc) r_mem[r_wr_ptr] <= bus.in_data;
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_mem[w_rd_ptr];
  assign bus.out_idx   = r_out_idx;
  assign bus.out_last  = w_out_last;
  assign busy          = w_busy;
  assign win_cnt       = r_win_cnt;
  assign o_dbg_state   = r_state;

`ifdef ECG_WIN_SUM_EN
  localparam int SW = N_BITS + AW;

  logic signed [SW-1:0] r_acc [N_CH];
  logic [N_CH*SW-1:0]   w_sum;

  function automatic logic signed [SW-1:0] sext(input logic [N_BITS-1:0] v);
    return SW'($signed(v));
  endfunction

  // Running per-channel sum of columns already handed off in this window.
  always_ff @(posedge clk) begin
    if (rst || (r_state != S_EMIT && w_next == S_EMIT)) begin
      for (int k = 0; k < N_CH; k++) r_acc[k] <= '0;
    end else if (w_emit_hs) begin
      for (int k = 0; k < N_CH; k++)
        r_acc[k] <= r_acc[k] + sext(bus.out_data[k*N_BITS +: N_BITS]);
    end
  end

  // Include the column currently presented so the total is complete at out_last.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N_CH; k++)
      w_sum[k*SW +: SW] = r_acc[k] + sext(bus.out_data[k*N_BITS +: N_BITS]);
  end

  assign bus.out_sum = w_sum;
`endif
endmodule

// File: doc/ecg_window_buffer.md
ECG_WINDOW_BUFFER -- requirements
Module: ecg_window_buffer

Interface
REQ-001 Parameter N_CH, default 8: number of ECG channels per sample column.
REQ-002 Parameter N_BITS, default 22: signed width of each channel sample.
REQ-003 Parameter WIN_LEN, default 32: window length in columns; power of two, at least 2.
REQ-004 Parameter HOP, default 32: new columns per subsequent window, 1..WIN_LEN (HOP < WIN_LEN gives overlap).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 strt  input  1  run enable; windowing proceeds only while high.
REQ-008 in_valid  input  1  in_data holds a valid column.
REQ-009 in_ready  output  1  block accepts a column this cycle.
REQ-010 in_data  input  N_CH*N_BITS  column; channel k in bits [k*N_BITS +: N_BITS].
REQ-011 out_valid  output  1  out_data holds a valid window column.
REQ-012 out_ready  input  1  downstream accepts the column.
REQ-013 out_data  output  N_CH*N_BITS  window column, same packing as in_data.
REQ-014 out_idx  output  $clog2(WIN_LEN)  column position in the window, 0 = oldest.
REQ-015 out_last  output  1  high with out_valid when out_idx == WIN_LEN-1.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 win_cnt  output  16  count of completed windows, wraps at 65535 -> 0.

Function
REQ-018 The FSM SHALL have the states IDLE, FILL and EMIT.
REQ-019 A column SHALL be accepted only on a cycle with in_valid && in_ready; in_ready SHALL be high only in FILL.
REQ-020 Storage SHALL be a circular buffer of WIN_LEN columns; the write pointer increments per accepted column and wraps WIN_LEN-1 -> 0.
REQ-021 IDLE -> FILL when strt=1; the fill target SHALL be WIN_LEN and the fill count SHALL be 0.
REQ-022 In FILL, the accept that brings the fill count to the target SHALL move the FSM to EMIT on the next edge; out_valid SHALL rise in the cycle after that final accept.
REQ-023 In EMIT, out_data SHALL present the oldest-first column at (write pointer + out_idx) mod WIN_LEN.
REQ-024 out_idx SHALL advance only on out_valid && out_ready; out_data and out_idx SHALL hold stable while out_valid && !out_ready.
REQ-025 On the out_last handshake: win_cnt increments; FSM -> FILL with target HOP and fill count 0 if strt=1, else -> IDLE.
REQ-026 strt falling in FILL SHALL force IDLE on the next edge and discard buffered history, so the next window needs a full WIN_LEN columns.
REQ-027 strt falling in EMIT SHALL NOT abort the current window; the block goes to IDLE after out_last.
REQ-028 out_valid and out_last SHALL be 0 outside EMIT.

Reset
REQ-029 rst=1 at a clock edge SHALL set: IDLE, write pointer 0, fill count 0, out_idx 0, win_cnt 0, in_ready 0, out_valid 0, out_last 0, busy 0, regardless of state.
REQ-030 Buffer contents need no reset; stale data SHALL never be emitted.

Configuration
REQ-031 Macro ECG_WIN_SUM_EN defined: adds output out_sum, width N_CH*(N_BITS+$clog2(WIN_LEN)), holding each channel's signed, sign-extended sum over all WIN_LEN window columns; valid when out_valid && out_last.
REQ-032 With the macro defined, the accumulator SHALL clear at the start of each EMIT and on reset.
REQ-033 ECG_WIN_SUM_EN undefined: no out_sum port and no accumulator logic; all other behaviour identical.

Verification
REQ-034 N_CH=2, N_BITS=8, WIN_LEN=4, HOP=4, strt=1, columns ch0=1..8, out_ready=1 -> windows {1,2,3,4} then {5,6,7,8}; out_last at idx 3; win_cnt=2.
REQ-035 WIN_LEN=4, HOP=2, inputs 1..8 -> windows {1,2,3,4}, {3,4,5,6}, {5,6,7,8}; in_ready=0 during each EMIT.
REQ-036 out_ready toggled 1,0,0,1 in EMIT -> out_idx/out_data held during the 0 cycles; no column is lost or repeated.
REQ-037 strt dropped after 2 of 4 columns, then reasserted -> next window contains only post-reassert columns; strt dropped mid-EMIT -> window completes, then IDLE, busy=0.
REQ-038 rst pulsed mid-EMIT at out_idx=2 -> next cycle out_valid=0, win_cnt=0, IDLE.
REQ-039 ECG_WIN_SUM_EN, N_BITS=8, window ch0 {127,127,127,127}, ch1 {-128,-1,0,1} -> out_sum ch0=508, ch1=-128 on out_last.
